// File: rtl/if_stage_module_if.sv
// Instruction-memory fetch handshake: req/addr from the fetch stage, ack/rdata back from memory.
interface if_stage_module_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   imem_req;
    logic [WORD_LENGTH-1:0] imem_addr;
    logic                   imem_ack;
    logic [WORD_LENGTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage_module.sv
// Instruction-fetch stage with IF/ID register: owns the PC, fetches over req/ack,
// buffers one word during decode freeze and discards in-flight data on a redirect.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_FETCH   | request outstanding on fetch_addr
// ST_HOLD    | word captured in hold_buf while decode is frozen, no request
// ST_DISCARD | redirect seen before ack; waiting out the stale request
module if_stage_module #(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [WORD_LENGTH-1:0] branch_address,
    if_stage_module_if.master      imem,
    output logic [WORD_LENGTH-1:0] pc_out,
    output logic [WORD_LENGTH-1:0] instruction_out,
    output logic                   valid_out
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]             state, state_nxt;
    logic [WORD_LENGTH-1:0] pc, pc_nxt;
    logic [WORD_LENGTH-1:0] fetch_addr, fetch_nxt;
    logic [WORD_LENGTH-1:0] hold_buf, hold_nxt;
    logic [WORD_LENGTH-1:0] addr_inc;
    logic [WORD_LENGTH-1:0] deliver_word;
    logic                   deliver;
    logic                   acked;
    logic                   run;

    // run keeps the request low until the first edge after reset release
    assign imem.imem_req  = run && (state != ST_HOLD);
    assign imem.imem_addr = fetch_addr;
    assign acked          = imem.imem_req && imem.imem_ack;
    assign addr_inc       = fetch_addr + WORD_LENGTH'(4);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        fetch_nxt    = fetch_addr;
        hold_nxt     = hold_buf;
        deliver      = 1'b0;
        deliver_word = imem.imem_rdata;
        case (state)
            ST_FETCH: begin
                if (acked && branch_taken) begin
                    pc_nxt    = branch_address;
                    fetch_nxt = branch_address;
                end else if (acked && !freeze) begin
                    deliver   = 1'b1;
                    pc_nxt    = addr_inc;
                    fetch_nxt = addr_inc;
                end else if (acked) begin
                    hold_nxt  = imem.imem_rdata;
                    state_nxt = ST_HOLD;
                end else if (branch_taken && imem.imem_req) begin
                    pc_nxt    = branch_address;
                    state_nxt = ST_DISCARD;
                end else if (branch_taken) begin
                    pc_nxt    = branch_address;
                    fetch_nxt = branch_address;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_nxt    = branch_address;
                    fetch_nxt = branch_address;
                    state_nxt = ST_FETCH;
                end else if (!freeze) begin
                    deliver      = 1'b1;
                    deliver_word = hold_buf;
                    pc_nxt       = addr_inc;
                    fetch_nxt    = addr_inc;
                    state_nxt    = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                // stale data is dropped; the newest redirect target wins
                if (acked) begin
                    pc_nxt    = branch_taken ? branch_address : pc;
                    fetch_nxt = branch_taken ? branch_address : pc;
                    state_nxt = ST_FETCH;
                end else if (branch_taken) begin
                    pc_nxt = branch_address;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            hold_buf   <= '0;
            run        <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fetch_addr <= fetch_nxt;
            hold_buf   <= hold_nxt;
            run        <= 1'b1;
        end
    end

    // IF/ID register: flush beats freeze, freeze beats load, otherwise bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else if (branch_taken) begin
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else if (freeze) begin
            pc_out          <= pc_out;
            instruction_out <= instruction_out;
            valid_out       <= valid_out;
        end else if (deliver) begin
            pc_out          <= addr_inc;
            instruction_out <= deliver_word;
            valid_out       <= 1'b1;
        end else begin
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage_module.sv
// Directed bench for if_stage_module: sequential fetch, wait states, freeze, redirects, wrap and reset.
module tb_if_stage_module;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        tie_ack = 1'b1;
    logic        ack_drv = 1'b0;
    logic        freeze1 = 1'b0;
    logic        branch1 = 1'b0;
    logic [31:0] branch_addr1 = '0;

    logic [31:0] pc_out0, instr0, pc_out1, instr1;
    logic        valid0, valid1;

    int checks = 0;
    int failures = 0;

    if_stage_module_if #(.WORD_LENGTH(32)) bus0 ();
    if_stage_module_if #(.WORD_LENGTH(32)) bus1 ();

    assign bus0.imem_ack   = tie_ack ? bus0.imem_req : ack_drv;
    assign bus0.imem_rdata = bus0.imem_addr | 32'hE000_0000;
    assign bus1.imem_ack   = bus1.imem_req;
    assign bus1.imem_rdata = bus1.imem_addr | 32'hE000_0000;

    if_stage_module #(.WORD_LENGTH(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem(bus0.master),
        .pc_out(pc_out0), .instruction_out(instr0), .valid_out(valid0)
    );

    if_stage_module #(.WORD_LENGTH(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze1), .branch_taken(branch1),
        .branch_address(branch_addr1), .imem(bus1.master),
        .pc_out(pc_out1), .instruction_out(instr1), .valid_out(valid1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held
        step();
        step();
        chk("rst_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, valid0}, 32'd0);
        chk("rst_pc_out", pc_out0, 32'd0);
        chk("rst_instr", instr0, 32'd0);

        rst = 1'b1;
        #1;
        chk("rel_req_low", {31'd0, bus0.imem_req}, 32'd0);

        // zero-wait sequential fetch
        step();
        chk("c1_req", {31'd0, bus0.imem_req}, 32'd1);
        chk("c1_addr", bus0.imem_addr, 32'd0);
        chk("c1_valid", {31'd0, valid0}, 32'd0);
        chk("wrap_addr0", bus1.imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_valid", {31'd0, valid0}, 32'd1);
            chk("seq_pc_out", pc_out0, 32'(4 * (i + 1)));
            chk("seq_instr", instr0, 32'hE000_0000 | 32'(4 * i));
            chk("seq_addr", bus0.imem_addr, 32'(4 * (i + 1)));
            if (i == 0) begin
                chk("wrap_addr1", bus1.imem_addr, 32'h0000_0000);
                chk("wrap_pc_out", pc_out1, 32'h0000_0000);
                chk("wrap_instr", instr1, 32'hFFFF_FFFC);
                chk("wrap_valid", {31'd0, valid1}, 32'd1);
            end
        end

        // freeze for 3 cycles while 0x10 is acked
        tie_ack = 1'b0;
        ack_drv = 1'b1;
        freeze  = 1'b1;
        step();
        ack_drv = 1'b0;
        chk("frz_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("frz_pc_out", pc_out0, 32'h10);
        chk("frz_instr", instr0, 32'hE000_000C);
        step();
        chk("frz2_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("frz2_valid", {31'd0, valid0}, 32'd1);
        step();
        chk("frz3_pc_out", pc_out0, 32'h10);
        freeze = 1'b0;
        step();
        chk("rel_valid", {31'd0, valid0}, 32'd1);
        chk("rel_pc_out", pc_out0, 32'h14);
        chk("rel_instr", instr0, 32'hE000_0010);
        chk("rel_req", {31'd0, bus0.imem_req}, 32'd1);
        chk("rel_addr", bus0.imem_addr, 32'h14);

        // two wait states per word
        for (int w = 0; w < 3; w++) begin
            ack_drv = 1'b0;
            step();
            chk("w1_valid", {31'd0, valid0}, 32'd0);
            chk("w1_addr", bus0.imem_addr, 32'h14 + 32'(4 * w));
            step();
            chk("w2_valid", {31'd0, valid0}, 32'd0);
            chk("w2_addr", bus0.imem_addr, 32'h14 + 32'(4 * w));
            ack_drv = 1'b1;
            step();
            chk("w3_valid", {31'd0, valid0}, 32'd1);
            chk("w3_pc_out", pc_out0, 32'h18 + 32'(4 * w));
            chk("w3_instr", instr0, 32'hE000_0014 + 32'(4 * w));
            chk("w3_addr", bus0.imem_addr, 32'h18 + 32'(4 * w));
        end

        // redirect with request to 0x20 outstanding
        ack_drv        = 1'b0;
        branch_taken   = 1'b1;
        branch_address = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("disc_addr", bus0.imem_addr, 32'h20);
        chk("disc_req", {31'd0, bus0.imem_req}, 32'd1);
        chk("disc_valid", {31'd0, valid0}, 32'd0);
        chk("disc_pc_out", pc_out0, 32'd0);
        step();
        chk("disc2_addr", bus0.imem_addr, 32'h20);
        chk("disc2_valid", {31'd0, valid0}, 32'd0);
        ack_drv = 1'b1;
        step();
        chk("disc_tgt_addr", bus0.imem_addr, 32'h100);
        chk("disc_drop_valid", {31'd0, valid0}, 32'd0);
        chk("disc_drop_instr", instr0, 32'd0);
        step();
        chk("tgt_valid", {31'd0, valid0}, 32'd1);
        chk("tgt_pc_out", pc_out0, 32'h104);
        chk("tgt_instr", instr0, 32'hE000_0100);
        chk("tgt_addr", bus0.imem_addr, 32'h104);

        // branch, freeze and ack together
        freeze         = 1'b1;
        branch_taken   = 1'b1;
        branch_address = 32'h200;
        step();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        chk("bf_valid", {31'd0, valid0}, 32'd0);
        chk("bf_pc_out", pc_out0, 32'd0);
        chk("bf_instr", instr0, 32'd0);
        chk("bf_req", {31'd0, bus0.imem_req}, 32'd1);
        chk("bf_addr", bus0.imem_addr, 32'h200);
        step();
        chk("bf_next_valid", {31'd0, valid0}, 32'd1);
        chk("bf_next_pc_out", pc_out0, 32'h204);
        chk("bf_next_instr", instr0, 32'hE000_0200);

        // reset asserted while a request waits
        ack_drv = 1'b0;
        rst     = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bus0.imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid0}, 32'd0);
        chk("mid_rst_pc_out", pc_out0, 32'd0);
        chk("mid_rst_instr", instr0, 32'd0);
        chk("mid_rst_req1", {31'd0, bus1.imem_req}, 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_addr", bus0.imem_addr, 32'd0);
        chk("post_rst_req", {31'd0, bus0.imem_req}, 32'd1);
        chk("post_rst_addr1", bus1.imem_addr, 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
